mem_port_arbiter: RTL



---
 rtl/mem_port_arbiter_pkg.sv | 26 ++
 rtl/mem_port_arbiter_priority.sv | 55 +++++
 rtl/mem_port_arbiter.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_pkg
// Shared types and default sizes for the unified-memory port arbiter.
//   arb_state_t : arbiter FSM states (IDLE / BUSY / RESP)
//   grant_t     : which requester owns the current memory access
//   ARB_*       : default parameter values used by mem_port_arbiter
// -----------------------------------------------------------------------------
package mem_port_arbiter_pkg;

  localparam int ARB_ADDR_W        = 32;
  localparam int ARB_DATA_W        = 32;
  localparam int ARB_MAX_DM_STREAK = 4;
  localparam int ARB_TIMEOUT       = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_DM = 1'b1
  } grant_t;

endpackage

// File: rtl/mem_port_arbiter_priority.sv
// -----------------------------------------------------------------------------
// arb_priority
// Winner selection between instruction fetch (IF) and data (DM) requesters.
// DM normally wins; after MAX_DM_STREAK consecutive DM grants made while IF
// was waiting, IF gets the next grant so fetch cannot starve.
// Ports:
//   clk_i, rst_i  clock, synchronous active-low reset
//   arb_i         an arbitration is taken this cycle (commits the streak update)
//   if_req_i      fetch request
//   dm_req_i      data request
//   gnt_o         winner for this cycle (combinational)
// -----------------------------------------------------------------------------
module arb_priority
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_DM_STREAK = ARB_MAX_DM_STREAK
) (
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   arb_i,
  input  logic   if_req_i,
  input  logic   dm_req_i,
  output grant_t gnt_o
);

  localparam int            SW         = $clog2(MAX_DM_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DM_STREAK);

  logic [SW-1:0] streak_q, streak_d;
  logic          if_turn;

  // IF only takes precedence once DM has used up its streak while IF waited.
  assign if_turn = if_req_i & (streak_q == STREAK_MAX);

  always_comb begin
    gnt_o = GNT_IF;
    if (dm_req_i && !if_turn) gnt_o = GNT_DM;
  end

  // The streak only measures how long IF has been passed over, so it resets
  // whenever IF wins or IF is not asking at all.
  always_comb begin
    streak_d = streak_q;
    if (arb_i) begin
      if (gnt_o == GNT_IF || !if_req_i) streak_d = '0;
      else if (streak_q != STREAK_MAX)  streak_d = streak_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) streak_q <= '0;
    else        streak_q <= streak_d;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-ported memory between the IF fetch port and the MEM-stage
// data port. One access at a time: IDLE picks a winner and latches its request,
// BUSY holds mem_req_o until mem_ack_i, RESP pulses the winner's ack for one
// cycle. stall_o is high while any request is still waiting for its ack.
// Optional build macro: ARB_TIMEOUT_EN adds a BUSY watchdog that completes the
// access with rdata 0 after TIMEOUT cycles and sets the sticky err_o flag.
// Ports:
//   clk_i, rst_i                        clock, synchronous active-low reset
//   if_req_i/if_addr_i                  fetch request (always a read)
//   if_ack_o/if_rdata_o                 fetch response
//   dm_req_i/dm_we_i/dm_addr_i/dm_wdata_i  data request
//   dm_ack_o/dm_rdata_o                 data response
//   mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o  memory request, held until ack
//   mem_ack_i/mem_rdata_i               memory completion, rdata valid with ack
//   stall_o                             pipeline stall
//   err_o                               sticky watchdog timeout flag
// -----------------------------------------------------------------------------
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W        = ARB_ADDR_W,
  parameter int DATA_W        = ARB_DATA_W,
  parameter int MAX_DM_STREAK = ARB_MAX_DM_STREAK,
  parameter int TIMEOUT       = ARB_TIMEOUT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_ack_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic              dm_ack_o,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              stall_o,
  output logic              err_o
);

  arb_state_t        state_q;
  grant_t            gnt_q, gnt_w;
  logic              arb_w, tmo_hit_w;
  logic              mem_req_q, mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              if_ack_q, dm_ack_q;
  logic [DATA_W-1:0] if_rdata_q, dm_rdata_q, resp_data_w;

  assign arb_w = (state_q == IDLE) & (if_req_i | dm_req_i);

  arb_priority #(
    .MAX_DM_STREAK(MAX_DM_STREAK)
  ) u_prio (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .arb_i   (arb_w),
    .if_req_i(if_req_i),
    .dm_req_i(dm_req_i),
    .gnt_o   (gnt_w)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int            TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] tmo_q;
  logic          err_q;

  // Fires in the TIMEOUT-th BUSY cycle if the memory still has not answered;
  // a real ack in that same cycle takes precedence.
  assign tmo_hit_w = (state_q == BUSY) & ~mem_ack_i & (tmo_q == TMO_LAST);

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (state_q != BUSY) tmo_q <= '0;
      else if (!mem_ack_i) tmo_q <= tmo_q + 1'b1;
      if (tmo_hit_w)       err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  assign tmo_hit_w = 1'b0;
  // Watchdog compiled out: err_o is 0 for any legal (positive) TIMEOUT.
  assign err_o = (TIMEOUT < 0);
`endif

  // A timed-out access returns zero instead of whatever is on the bus.
  assign resp_data_w = mem_ack_i ? mem_rdata_i : '0;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      gnt_q       <= GNT_IF;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (if_req_i || dm_req_i) begin
            gnt_q     <= gnt_w;
            mem_req_q <= 1'b1;
            state_q   <= BUSY;
            if (gnt_w == GNT_DM) begin
              mem_we_q    <= dm_we_i;
              mem_addr_q  <= dm_addr_i;
              mem_wdata_q <= dm_wdata_i;
            end else begin
              mem_we_q    <= 1'b0;
              mem_addr_q  <= if_addr_i;
              mem_wdata_q <= '0;
            end
          end
        end
        BUSY: begin
          if (mem_ack_i || tmo_hit_w) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            state_q   <= RESP;
            if (gnt_q == GNT_DM) begin
              dm_rdata_q <= resp_data_w;
              dm_ack_q   <= 1'b1;
            end else begin
              if_rdata_q <= resp_data_w;
              if_ack_q   <= 1'b1;
            end
          end
        end
        RESP: begin
          if_ack_q <= 1'b0;
          dm_ack_q <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign if_ack_o    = if_ack_q;
  assign dm_ack_o    = dm_ack_q;
  assign if_rdata_o  = if_rdata_q;
  assign dm_rdata_o  = dm_rdata_q;

  assign stall_o = (if_req_i & ~if_ack_q) | (dm_req_i & ~dm_ack_q);

endmodule
